// File: rtl/paddle_track.sv
// Paddle on a 1-D track: divided step movement with saturation, ball-vs-paddle
// hit/miss detection with zone classification, and a blanking window after each result.
module paddle_track #(
    parameter int TRACK_W  = 128,
    parameter int PAD_LEN  = 16,
    parameter int MOVE_DIV = 4,
    parameter int HOLD_CYC = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        kill,
    input  logic                        moveUp,
    input  logic                        moveDown,
    input  logic                        inPaddleRange,
    input  logic [$clog2(TRACK_W)-1:0]  ball_y,
    output logic [TRACK_W-1:0]          pad_map,
    output logic [$clog2(TRACK_W)-1:0]  pad_pos,
    output logic                        isHit,
    output logic                        miss,
    output logic [1:0]                  hit_zone
);

    localparam int YW  = $clog2(TRACK_W);
    localparam int YW1 = YW + 1;
    localparam int DW  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int HW  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [YW-1:0] CENTER    = YW'((TRACK_W - PAD_LEN) / 2);
    localparam logic [YW-1:0] MAX_POS   = YW'(TRACK_W - PAD_LEN);
    localparam logic [DW-1:0] DIV_LAST  = DW'(MOVE_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [YW:0]   LEN_W     = YW1'(PAD_LEN);
    localparam logic [YW:0]   LOW_END   = YW1'(PAD_LEN / 4);
    localparam logic [YW:0]   HIGH_BEG  = YW1'(PAD_LEN - PAD_LEN / 4);

    function automatic logic [TRACK_W-1:0] base_mask();
        logic [TRACK_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAD_LEN; i++) m[i] = 1'b1;
        return m;
    endfunction

    localparam logic [TRACK_W-1:0] BASE_MASK  = base_mask();
    localparam logic [TRACK_W-1:0] CENTER_MAP = BASE_MASK << CENTER;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        READY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [DW-1:0]   div_cnt;
    logic [HW-1:0]   hold_cnt;

    logic            move_req;
    logic            step;
    logic [YW-1:0]   pos_next;
    logic [DW-1:0]   div_next;
    logic [YW:0]     off;
    logic            in_pad;
    logic [1:0]      zone;

    assign move_req = moveUp ^ moveDown;
    assign step     = move_req && (div_cnt == '0);

    always_comb begin
        pos_next = pad_pos;
        if (step) begin
            if (moveUp) begin
                if (pad_pos != MAX_POS) pos_next = pad_pos + 1'b1;
            end else begin
                if (pad_pos != '0) pos_next = pad_pos - 1'b1;
            end
        end

        div_next = '0;
        if (move_req) div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;

        // A ball below the paddle wraps to a large value and falls out as a miss.
        off    = {1'b0, ball_y} - {1'b0, pad_pos};
        in_pad = off < LEN_W;
        if (off < LOW_END)        zone = 2'b01;
        else if (off >= HIGH_BEG) zone = 2'b11;
        else                      zone = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= READY;
            pad_pos  <= CENTER;
            pad_map  <= CENTER_MAP;
            div_cnt  <= '0;
            hold_cnt <= '0;
            isHit    <= 1'b0;
            miss     <= 1'b0;
            hit_zone <= 2'b00;
        end else if (kill) begin
            // Re-centre while killed so leaving OFF only has to relight the map.
            state    <= OFF;
            pad_pos  <= CENTER;
            pad_map  <= '0;
            div_cnt  <= '0;
            hold_cnt <= '0;
            isHit    <= 1'b0;
            miss     <= 1'b0;
            hit_zone <= 2'b00;
        end else begin
            isHit    <= 1'b0;
            miss     <= 1'b0;
            hit_zone <= 2'b00;
            case (state)
                OFF: begin
                    state   <= READY;
                    pad_map <= CENTER_MAP;
                end
                READY: begin
                    pad_pos <= pos_next;
                    pad_map <= BASE_MASK << pos_next;
                    div_cnt <= div_next;
                    if (inPaddleRange) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                        if (in_pad) begin
                            isHit    <= 1'b1;
                            hit_zone <= zone;
                        end else begin
                            miss     <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    pad_pos <= pos_next;
                    pad_map <= BASE_MASK << pos_next;
                    div_cnt <= div_next;
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= READY;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_track.sv
// Bench for paddle_track: directed scenarios plus a random run against a
// cycle-count based reference model of paddle movement and detection.
module tb_paddle_track;

    localparam int TRACK_W  = 128;
    localparam int PAD_LEN  = 16;
    localparam int MOVE_DIV = 4;
    localparam int HOLD_CYC = 8;
    localparam int YW       = $clog2(TRACK_W);
    localparam int CENTER   = (TRACK_W - PAD_LEN) / 2;

    logic               clk;
    logic               reset;
    logic               kill;
    logic               moveUp;
    logic               moveDown;
    logic               inPaddleRange;
    logic [YW-1:0]      ball_y;
    logic [TRACK_W-1:0] pad_map;
    logic [YW-1:0]      pad_pos;
    logic               isHit;
    logic               miss;
    logic [1:0]         hit_zone;

    paddle_track #(
        .TRACK_W(TRACK_W), .PAD_LEN(PAD_LEN), .MOVE_DIV(MOVE_DIV), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .reset(reset), .kill(kill), .moveUp(moveUp), .moveDown(moveDown),
        .inPaddleRange(inPaddleRange), .ball_y(ball_y), .pad_map(pad_map),
        .pad_pos(pad_pos), .isHit(isHit), .miss(miss), .hit_zone(hit_zone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: paddle position, press length in cycles, and the first
    // edge index at which detection is allowed again.
    int                 m_pos;
    bit                 m_off;
    int                 m_press;
    int                 m_ready_at;
    int                 m_cyc = 0;
    logic               e_hit;
    logic               e_miss;
    logic [1:0]         e_zone;
    logic [TRACK_W-1:0] e_map;
    logic [YW-1:0]      e_pos;
    logic [TRACK_W-1:0] center_map;

    task automatic model_step(input logic r, k, u, d, ip, input int by);
        e_hit  = 1'b0;
        e_miss = 1'b0;
        e_zone = 2'b00;
        if (r) begin
            m_pos = CENTER; m_off = 0; m_press = 0; m_ready_at = m_cyc + 1;
        end else if (k) begin
            m_off = 1; m_pos = CENTER; m_press = 0;
        end else if (m_off) begin
            m_off = 0; m_ready_at = m_cyc + 1;
        end else begin
            if (ip && m_cyc >= m_ready_at) begin
                int off;
                off = by - m_pos;
                if (off >= 0 && off < PAD_LEN) begin
                    e_hit = 1'b1;
                    if (off < PAD_LEN / 4)                    e_zone = 2'b01;
                    else if (off >= PAD_LEN - PAD_LEN / 4)    e_zone = 2'b11;
                    else                                      e_zone = 2'b10;
                end else begin
                    e_miss = 1'b1;
                end
                m_ready_at = m_cyc + HOLD_CYC + 1;
            end
            if (u != d) begin
                if (m_press % MOVE_DIV == 0) begin
                    if (u) m_pos = (m_pos + 1 > TRACK_W - PAD_LEN) ? TRACK_W - PAD_LEN : m_pos + 1;
                    else   m_pos = (m_pos - 1 < 0) ? 0 : m_pos - 1;
                end
                m_press++;
            end else begin
                m_press = 0;
            end
        end
        for (int i = 0; i < TRACK_W; i++)
            e_map[i] = !m_off && (i >= m_pos) && (i < m_pos + PAD_LEN);
        e_pos = YW'(m_pos);
        m_cyc++;
    endtask

    task automatic drive(input logic r, k, u, d, ip, input int by);
        reset = r; kill = k; moveUp = u; moveDown = d; inPaddleRange = ip;
        ball_y = YW'(by);
        model_step(r, k, u, d, ip, by);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0);
        total++; if (pad_pos !== 7'd56) begin bad++; $display("FAIL reset_pos: got %0d want 56", pad_pos); end
        total++; if (pad_map !== center_map) begin bad++; $display("FAIL reset_map: got %h want %h", pad_map, center_map); end
        total++; if (isHit !== 1'b0 || miss !== 1'b0 || hit_zone !== 2'b00) begin
            bad++; $display("FAIL reset_pulses: got hit=%b miss=%b zone=%b want 0 0 00", isHit, miss, hit_zone);
        end
    endtask

    task automatic test_move();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            total++; if (pad_pos !== e_pos) begin bad++; $display("FAIL move_cyc%0d: got %0d want %0d", i, pad_pos, e_pos); end
        end
        total++; if (pad_pos !== 7'd59) begin bad++; $display("FAIL move_end: got %0d want 59", pad_pos); end
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 1, 0, 0);
        total++; if (pad_pos !== 7'd59) begin bad++; $display("FAIL move_both: got %0d want 59", pad_pos); end
        total++; if (pad_map !== e_map) begin bad++; $display("FAIL move_map: got %h want %h", pad_map, e_map); end
    endtask

    task automatic test_limits();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 240; i++) drive(0, 0, 1, 0, 0, 0);
        total++; if (pad_pos !== 7'd112) begin bad++; $display("FAIL limit_top: got %0d want 112", pad_pos); end
        for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0, 0);
        total++; if (pad_pos !== 7'd112) begin bad++; $display("FAIL limit_top_hold: got %0d want 112", pad_pos); end
        total++; if (pad_map !== e_map) begin bad++; $display("FAIL limit_top_map: got %h want %h", pad_map, e_map); end
        for (int i = 0; i < 470; i++) drive(0, 0, 0, 1, 0, 0);
        total++; if (pad_pos !== 7'd0) begin bad++; $display("FAIL limit_bot: got %0d want 0", pad_pos); end
        for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 0, 0);
        total++; if (pad_pos !== 7'd0) begin bad++; $display("FAIL limit_bot_hold: got %0d want 0", pad_pos); end
    endtask

    task automatic test_detect();
        int         ys[5] = '{57, 64, 71, 72, 55};
        logic [1:0] zs[5] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
        logic       hs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            drive(0, 0, 0, 0, 1, ys[i]);
            total++; if (isHit !== hs[i] || miss !== !hs[i] || hit_zone !== zs[i]) begin
                bad++; $display("FAIL detect_y%0d: got hit=%b miss=%b zone=%b want %b %b %b",
                                ys[i], isHit, miss, hit_zone, hs[i], !hs[i], zs[i]);
            end
            drive(0, 0, 0, 0, 0, 0);
            total++; if (isHit !== 1'b0 || miss !== 1'b0 || hit_zone !== 2'b00) begin
                bad++; $display("FAIL detect_pulse_y%0d: got hit=%b miss=%b zone=%b want 0 0 00", ys[i], isHit, miss, hit_zone);
            end
        end
    endtask

    task automatic test_hold();
        int hits = 0;
        int second = -1;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 1, 60);
            total++; if (isHit !== e_hit) begin bad++; $display("FAIL hold_cyc%0d: got hit=%b want %b", i, isHit, e_hit); end
            if (isHit === 1'b1) begin
                hits++;
                if (hits == 2) second = i;
            end
        end
        total++; if (hits != 2) begin bad++; $display("FAIL hold_count: got %0d hits want 2", hits); end
        total++; if (second != HOLD_CYC + 1) begin bad++; $display("FAIL hold_second: got cycle %0d want %0d", second, HOLD_CYC + 1); end
    endtask

    task automatic test_kill();
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 60);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 1, 60);
            total++; if (pad_map !== '0 || isHit !== 1'b0 || miss !== 1'b0) begin
                bad++; $display("FAIL kill_cyc%0d: got map=%h hit=%b miss=%b want 0 0 0", i, pad_map, isHit, miss);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        total++; if (pad_pos !== 7'd56 || pad_map !== center_map) begin
            bad++; $display("FAIL kill_release: got pos=%0d map=%h want 56 %h", pad_pos, pad_map, center_map);
        end
        drive(0, 0, 0, 0, 1, 60);
        total++; if (isHit !== 1'b1 || hit_zone !== 2'b10) begin
            bad++; $display("FAIL kill_ready: got hit=%b zone=%b want 1 10", isHit, hit_zone);
        end
        drive(0, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 1, 60);
        total++; if (pad_pos !== 7'd56 || pad_map !== center_map || isHit !== 1'b0 || miss !== 1'b0) begin
            bad++; $display("FAIL kill_reset: got pos=%0d map=%h hit=%b miss=%b want 56 %h 0 0",
                            pad_pos, pad_map, isHit, miss, center_map);
        end
    endtask

    task automatic test_random();
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            logic r, k, u, d, ip;
            int by;
            r  = ($urandom_range(0, 99) < 2);
            k  = ($urandom_range(0, 99) < 4);
            u  = ($urandom_range(0, 99) < 60);
            d  = ($urandom_range(0, 99) < 35);
            ip = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 1) == 1) by = $urandom_range(0, TRACK_W - 1);
            else by = m_pos + $urandom_range(0, PAD_LEN - 1);
            drive(r, k, u, d, ip, by);
            total++; if (pad_pos !== e_pos || pad_map !== e_map) begin
                bad++; $display("FAIL rand_pos_cyc%0d: got pos=%0d map=%h want %0d %h", i, pad_pos, pad_map, e_pos, e_map);
            end
            total++; if (isHit !== e_hit || miss !== e_miss || hit_zone !== e_zone) begin
                bad++; $display("FAIL rand_det_cyc%0d: got hit=%b miss=%b zone=%b want %b %b %b",
                                i, isHit, miss, hit_zone, e_hit, e_miss, e_zone);
            end
        end
    endtask

    initial begin
        center_map = 128'hFFFF << 56;
        reset = 1'b1; kill = 1'b0; moveUp = 1'b0; moveDown = 1'b0;
        inPaddleRange = 1'b0; ball_y = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_move();
        test_limits();
        test_detect();
        test_hold();
        test_kill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/paddle_track.md
PADDLE_TRACK -- requirements
Module: paddle_track

Interface
REQ-001 The block SHALL have parameter TRACK_W, default 128: track length in cells, at least 8.
REQ-002 The block SHALL have parameter PAD_LEN, default 16: paddle length in cells, at least 4 and at most TRACK_W.
REQ-003 The block SHALL have parameter MOVE_DIV, default 4: cycles per step while a move input is held, at least 1.
REQ-004 The block SHALL have parameter HOLD_CYC, default 8: cycles collision detection stays blanked after a hit or miss, at least 1.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port kill, input, 1 bit: synchronous disable; blanks the paddle.
REQ-008 The block SHALL have ports moveUp and moveDown, input, 1 bit each: move requests.
REQ-009 The block SHALL have port inPaddleRange, input, 1 bit: the ball is in the paddle column this cycle.
REQ-010 The block SHALL have port ball_y, input, YW=$clog2(TRACK_W) bits: ball row.
REQ-011 The block SHALL have port pad_map, output, TRACK_W bits: paddle bitmap, 1 = lit cell.
REQ-012 The block SHALL have port pad_pos, output, YW bits: lowest occupied row.
REQ-013 The block SHALL have ports isHit and miss, output, 1 bit each: one-cycle result pulses.
REQ-014 The block SHALL have port hit_zone, output, 2 bits: 01 = low, 10 = center, 11 = high, 00 = none.

Function
REQ-015 State machine states SHALL be OFF, READY and HOLD; all outputs SHALL be registered.
REQ-016 pad_pos SHALL stay within 0..TRACK_W-PAD_LEN; pad_map bits pad_pos..pad_pos+PAD_LEN-1 SHALL be 1 and all others 0, except in OFF, where pad_map SHALL be all 0.
REQ-017 move_req SHALL be defined as exactly one of moveUp and moveDown being asserted; both asserted or neither SHALL count as no request and clear the divider counter to 0.
REQ-018 While move_req holds, the divider SHALL count 0..MOVE_DIV-1 and wrap; a step SHALL occur on each cycle the counter is 0, so the first step happens on the first cycle of the press.
REQ-019 A step SHALL change pad_pos by +1 for moveUp and by -1 for moveDown.
REQ-020 At either limit, a step SHALL saturate: pad_pos is unchanged and there is no wrap-around, while the counter keeps running.
REQ-021 READY with inPaddleRange=1 SHALL compute off = ball_y - pad_pos (unsigned, YW+1 bits) against pad_pos as it was before any same-cycle step.
REQ-022 If 0 <= off < PAD_LEN, the block SHALL pulse isHit=1 on the next cycle, with hit_zone=01 for off < PAD_LEN/4, 11 for off >= PAD_LEN-PAD_LEN/4, and 10 otherwise.
REQ-023 If off is outside 0..PAD_LEN-1, the block SHALL pulse miss=1 on the next cycle, with hit_zone=00.
REQ-024 isHit, miss and hit_zone SHALL each be valid for exactly one cycle and SHALL otherwise be 0.
REQ-025 A hit or miss SHALL move the FSM from READY to HOLD, where inPaddleRange is ignored for HOLD_CYC cycles before returning to READY; movement SHALL stay active during HOLD.
REQ-026 kill=1 SHALL move the FSM to OFF from any state, ignore moves and detection, and force isHit and miss to 0.
REQ-027 The cycle after kill falls, the FSM SHALL enter READY with pad_pos at the center value and the divider at 0.
REQ-028 Priority SHALL be reset > kill > normal operation.

Reset
REQ-029 reset=1 SHALL set the FSM to READY, pad_pos to the center value (TRACK_W-PAD_LEN)/2, divider and hold counter to 0, and isHit, miss and hit_zone to 0.
REQ-030 Reset SHALL set pad_map to the center bitmap, which is 56..71 with the default parameters.
REQ-031 Reset mid-HOLD or mid-press SHALL abort the operation; the press SHALL restart its divider from 0 after reset falls.

Verification
REQ-032 Bench SHALL check: reset -> pad_pos=56, pad_map=bits 56..71 set, isHit=miss=0.
REQ-033 Bench SHALL check: moveUp held 9 cycles from pos 56, MOVE_DIV=4 -> steps on cycles 0, 4 and 8, ending at pos 59; both inputs high -> no step.
REQ-034 Bench SHALL check: moveUp held at pos 112 -> stays at 112; moveDown at pos 0 -> stays at 0.
REQ-035 Bench SHALL check: pos 56 with inPaddleRange=1 and ball_y=57, 64, 71 -> isHit with zones 01, 10, 11 respectively; ball_y=72 or 55 -> miss with zone 00.
REQ-036 Bench SHALL check: inPaddleRange held 10 cycles over the paddle -> exactly one isHit, then a second isHit only after HOLD_CYC=8 blanked cycles.
REQ-037 Bench SHALL check: kill asserted mid-HOLD -> pad_map=0 with no pulses; kill released -> READY at pos 56; reset together with kill -> reset values.
